// File: rtl/fp16_align_stage.sv
// fp16_align_stage: FP16 adder operand unpack, magnitude order/swap and exponent-difference stage.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_a/in_b operand pair handshake;
// out_valid/out_ready result handshake; out_sign_big, out_eff_sub, out_exp, out_mant_big,
// out_mant_small, out_shift, out_nan, out_inf, out_sticky feed the mantissa right shifter.
// Optional macro FP16_ALIGN_STICKY_EN enables sticky computation; otherwise out_sticky is 0.
module fp16_align_stage #(
  parameter int PIPE_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign_big,
  output logic        out_eff_sub,
  output logic [4:0]  out_exp,
  output logic [10:0] out_mant_big,
  output logic [10:0] out_mant_small,
  output logic [3:0]  out_shift,
  output logic        out_nan,
  output logic        out_inf,
  output logic        out_sticky
);
  if (PIPE_STAGES != 2) begin : g_bad_depth
    $error("fp16_align_stage: PIPE_STAGES must be 2");
  end
  logic        s1_valid, s1_sa, s1_sb, s1_abig, s1_nan, s1_inf;
  logic [4:0]  s1_ea, s1_eb;
  logic [10:0] s1_ma, s1_mb;
  logic        s2_adv, s1_adv;
  logic        a_inf, b_inf, a_nan, b_nan, nan0, inf0;
  logic [4:0]  a_exp, b_exp, e_big, e_small, e_diff;
  logic [10:0] m_small;
  logic [3:0]  shift;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  // Subnormals and zero share effective exponent 1 with no hidden bit.
  assign a_exp = (in_a[14:10] == 5'd0) ? 5'd1 : in_a[14:10];
  assign b_exp = (in_b[14:10] == 5'd0) ? 5'd1 : in_b[14:10];
  assign a_inf = (&in_a[14:10]) && !(|in_a[9:0]);
  assign b_inf = (&in_b[14:10]) && !(|in_b[9:0]);
  assign a_nan = (&in_a[14:10]) && (|in_a[9:0]);
  assign b_nan = (&in_b[14:10]) && (|in_b[9:0]);
  assign nan0  = a_nan || b_nan || (a_inf && b_inf && (in_a[15] ^ in_b[15]));
  assign inf0  = !nan0 && (a_inf || b_inf);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      {s1_sa, s1_sb, s1_abig, s1_nan, s1_inf} <= '0;
      {s1_ea, s1_eb, s1_ma, s1_mb} <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sa   <= in_a[15];
        s1_sb   <= in_b[15];
        s1_ea   <= a_exp;
        s1_eb   <= b_exp;
        s1_ma   <= {|in_a[14:10], in_a[9:0]};
        s1_mb   <= {|in_b[14:10], in_b[9:0]};
        s1_abig <= in_a[14:0] >= in_b[14:0];
        s1_nan  <= nan0;
        s1_inf  <= inf0;
      end
    end
  end
  // Magnitude order implies exponent order, so the difference never wraps.
  assign e_big   = s1_abig ? s1_ea : s1_eb;
  assign e_small = s1_abig ? s1_eb : s1_ea;
  assign e_diff  = e_big - e_small;
  assign shift   = e_diff[4] ? 4'hf : e_diff[3:0];
  assign m_small = s1_abig ? s1_mb : s1_ma;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      {out_sign_big, out_eff_sub, out_nan, out_inf} <= '0;
      {out_exp, out_mant_big, out_mant_small, out_shift} <= '0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      if (s1_adv) begin
        out_sign_big   <= s1_abig ? s1_sa : s1_sb;
        out_eff_sub    <= s1_sa ^ s1_sb;
        out_exp        <= e_big;
        out_mant_big   <= s1_abig ? s1_ma : s1_mb;
        out_mant_small <= m_small;
        out_shift      <= shift;
        out_nan        <= s1_nan;
        out_inf        <= s1_inf;
      end
    end
  end
`ifdef FP16_ALIGN_STICKY_EN
  // Shifting the all-ones mask by >= 11 empties it, so the OR covers all 11 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_sticky <= 1'b0;
    else if (s1_adv) out_sticky <= |(m_small & ~(11'h7ff << shift));
  end
`else
  assign out_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_fp16_align_stage.sv
// tb_fp16_align_stage: scoreboard bench for fp16_align_stage with directed and random traffic.
module tb_fp16_align_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign_big, out_eff_sub, out_nan, out_inf, out_sticky;
  logic [4:0]  out_exp;
  logic [10:0] out_mant_big, out_mant_small;
  logic [3:0]  out_shift;
  logic [35:0] obs;
  logic [35:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  logic st_ex;

  fp16_align_stage #(.PIPE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_big(out_sign_big), .out_eff_sub(out_eff_sub), .out_exp(out_exp),
    .out_mant_big(out_mant_big), .out_mant_small(out_mant_small), .out_shift(out_shift),
    .out_nan(out_nan), .out_inf(out_inf), .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  assign obs = {out_sign_big, out_eff_sub, out_exp, out_mant_big, out_mant_small,
                out_shift, out_nan, out_inf, out_sticky};

`ifdef FP16_ALIGN_STICKY_EN
  initial st_ex = 1'b1;
`else
  initial st_ex = 1'b0;
`endif

  task automatic chk(input string tag, input logic [35:0] o, input logic [35:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [35:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea = int'(a[14:10]);
    int eb = int'(b[14:10]);
    int fa = int'(a[9:0]);
    int fb = int'(b[9:0]);
    int xa = (ea == 0) ? 1 : ea;
    int xb = (eb == 0) ? 1 : eb;
    int ma = fa + ((ea != 0) ? 1024 : 0);
    int mb = fb + ((eb != 0) ? 1024 : 0);
    bit abig = (ea * 1024 + fa) >= (eb * 1024 + fb);
    int xg = abig ? xa : xb;
    int xs = abig ? xb : xa;
    int mg = abig ? ma : mb;
    int ms = abig ? mb : ma;
    bit sg = abig ? a[15] : b[15];
    int sh = (xg - xs > 15) ? 15 : xg - xs;
    int k = (sh > 11) ? 11 : sh;
    bit st = 1'b0;
    bit na = (ea == 31) && (fa != 0);
    bit nb = (eb == 31) && (fb != 0);
    bit ia = (ea == 31) && (fa == 0);
    bit ib = (eb == 31) && (fb == 0);
    bit nan = na || nb || (ia && ib && (a[15] != b[15]));
    bit inf = !nan && (ia || ib);
`ifdef FP16_ALIGN_STICKY_EN
    st = (ms % (1 << k)) != 0;
`endif
    return {sg, a[15] ^ b[15], 5'(xg), 11'(mg), 11'(ms), 4'(sh), nan, inf, st};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL sb_empty: observed output %h expected none", obs);
        end else begin
          chk("data", obs, sb.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic one(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [35:0] e);
    send(a, b);
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    #1 chk({tag, "_lat2"}, out_valid, 1);
    chk(tag, obs, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1 chk("drain", sb.size(), 0);
  endtask

  initial begin
    int acc;
    int cyc;
    int n0;
    #23;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", obs, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    one("basic", 16'h3c00, 16'h3800, {1'b0, 1'b0, 5'd15, 11'h400, 11'h400, 4'd1, 3'b000});
    one("swap_sub", 16'h0001, 16'h8400, {1'b1, 1'b1, 5'd1, 11'h400, 11'h001, 4'd0, 3'b000});
    one("sat", 16'h7bff, 16'h0001, {1'b0, 1'b0, 5'd30, 11'h7ff, 11'h001, 4'd15, 2'b00, st_ex});
    one("tie", 16'h3c00, 16'hbc00, {1'b0, 1'b1, 5'd15, 11'h400, 11'h400, 4'd0, 3'b000});
    one("zeros", 16'h0000, 16'h8000, {1'b0, 1'b1, 5'd1, 11'h000, 11'h000, 4'd0, 3'b000});
    send(16'h7e00, 16'h3c00);
    @(posedge clk);
    #1 chk("nan_op", {out_nan, out_inf}, 2'b10);
    send(16'h7c00, 16'hfc00);
    @(posedge clk);
    #1 chk("inf_diff", {out_nan, out_inf}, 2'b10);
    send(16'h7c00, 16'h3c00);
    @(posedge clk);
    #1 chk("inf_one", {out_nan, out_inf}, 2'b01);
    send(16'h7c00, 16'h7c00);
    @(posedge clk);
    #1 chk("inf_same", {out_nan, out_inf}, 2'b01);
    drain();
    n0 = n_out;
    out_ready = 1'b0;
    send(16'h4000, 16'h3000);
    send(16'h4400, 16'hc000);
    in_a = 16'h4800;
    in_b = 16'h0200;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", obs, model(16'h4000, 16'h3000));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h4800, 16'h0200);
    send(16'hcc00, 16'h4c01);
    drain();
    chk("bp_count", n_out - n0, 4);
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      logic [15:0] va, vb;
      int s;
      va = 16'($urandom);
      vb = 16'($urandom);
      s = $urandom_range(0, 7);
      if (s == 0) va[14:10] = 5'd31;
      if (s == 1) vb[14:10] = 5'd0;
      if (s == 2) vb[14:10] = va[14:10];
      in_a = va;
      in_b = vb;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_acc", acc, 1000);
    drain();
    out_ready = 1'b0;
    send(16'h5000, 16'h4000);
    send(16'h5400, 16'h3c00);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_data", obs, 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    one("post_rst", 16'h3c00, 16'h3800, {1'b0, 1'b0, 5'd15, 11'h400, 11'h400, 4'd1, 3'b000});
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
